imem_dmem_arbiter: RTL and testbench

Shares the single memory port between the instruction-fetch requester (read-only, driven by the fetch step) and the data requester (load/store, driven by the memory step). It sequences one memory transaction at a time with a request/acknowledge handshake. Arbitration is round-robin when both sides request together. A timeout returns an error response when memory never acknowledges, so a stuck memory cannot hang the pipeline.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 23 ++
 rtl/imem_dmem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  localparam int unsigned ARB_ADDR_W  = 32;
  localparam int unsigned ARB_DATA_W  = 32;
  localparam int unsigned ARB_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant: a lone requester wins, a tie
// goes to the requester that was not granted last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    if (&req_i) begin
      gnt_id_o = ~last_i;
    end else if (req_i[REQ_IF]) begin
      gnt_id_o = REQ_IF;
    end else begin
      gnt_id_o = REQ_DM;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// transaction at a time, with round-robin arbitration and a busy timeout.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ARB_ADDR_W,
  parameter int unsigned DATA_W  = ARB_DATA_W,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic                if_err_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  input  logic [DATA_W/8-1:0] dm_wstrb_i,
  output logic                dm_ack_o,
  output logic                dm_err_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int unsigned STRB_W = DATA_W / 8;
  // A zero TIMEOUT would give a zero-width counter; keep one bit in that case.
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  logic                last_q, last_d;
  logic                winner_q, winner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic                dm_ack_q, dm_ack_d, dm_err_q, dm_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic                gnt_valid, gnt_id, timed_out;

  rr_arbiter2 u_rr (
    .req_i       ({dm_req_i, if_req_i}),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    winner_d    = winner_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    dm_ack_d    = 1'b0;
    dm_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          winner_d  = gnt_id;
          last_d    = gnt_id;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          if (gnt_id == REQ_DM) begin
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
            mem_wstrb_d = dm_wstrb_i;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A real acknowledge wins over a timeout landing on the same edge.
        if (mem_ack_i) begin
          if (winner_q == REQ_DM) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = mem_rdata_i;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
          mem_req_d = 1'b0;
          state_d   = ARB_RESP;
        end else if (timed_out) begin
          if (winner_q == REQ_DM) begin
            dm_ack_d = 1'b1;
            dm_err_d = 1'b1;
          end else begin
            if_ack_d = 1'b1;
            if_err_d = 1'b1;
          end
          mem_req_d = 1'b0;
          state_d   = ARB_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_RESP: begin
        cnt_d   = '0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      last_q      <= REQ_DM;
      winner_q    <= REQ_IF;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      winner_q    <= winner_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_ack_q    <= if_ack_d;
      if_err_q    <= if_err_d;
      dm_ack_q    <= dm_ack_d;
      dm_err_q    <= dm_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_err_o    = if_err_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_ack_o    = dm_ack_q;
  assign dm_err_o    = dm_err_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: TIMEOUT=8 main instance plus a
// TIMEOUT=4 instance on the same stimulus for the ack-at-timeout case.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        if_ack, if_err, dm_ack, dm_err, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        if_ack4, if_err4, dm_ack4, dm_err4, mem_req4, mem_we4;
  logic [31:0] if_rdata4, dm_rdata4, mem_addr4, mem_wdata4;
  logic [3:0]  mem_wstrb4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_ack_o(if_ack), .if_err_o(if_err), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_wstrb_i(dm_wstrb),
    .dm_ack_o(dm_ack), .dm_err_o(dm_err), .dm_rdata_o(dm_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_ack_o(if_ack4), .if_err_o(if_err4), .if_rdata_o(if_rdata4),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_wstrb_i(dm_wstrb),
    .dm_ack_o(dm_ack4), .dm_err_o(dm_err4), .dm_rdata_o(dm_rdata4),
    .mem_req_o(mem_req4), .mem_we_o(mem_we4), .mem_addr_o(mem_addr4),
    .mem_wdata_o(mem_wdata4), .mem_wstrb_o(mem_wstrb4),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  // Outputs are sampled and inputs changed 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_req, mem_we, if_ack, if_err, dm_ack, dm_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got req/we/ifack/iferr/dmack/dmerr=%b want 000000",
               {mem_req, mem_we, if_ack, if_err, dm_ack, dm_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb, if_rdata, dm_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h wstrb=%h ifr=%h dmr=%h want all 0",
               mem_addr, mem_wdata, mem_wstrb, if_rdata, dm_rdata);
    end
  endtask

  task automatic test_if_read();
    int dm_seen = 0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h8000_0000;
    step();
    checks++;
    if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h8000_0000) begin
      errors++;
      $display("FAIL if_issue got req=%b we=%b addr=%h want 1 0 80000000",
               mem_req, mem_we, mem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      if (if_ack || dm_ack) dm_seen++;
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    step();
    if (dm_ack) dm_seen++;
    checks++;
    if ({if_ack, if_err, mem_req} !== 3'b100 || if_rdata !== 32'h0000_0013) begin
      errors++;
      $display("FAIL if_done got ack=%b err=%b req=%b rdata=%h want 1 0 0 00000013",
               if_ack, if_err, mem_req, if_rdata);
    end
    mem_ack = 1'b0; if_req = 1'b0;
    step();
    if (dm_ack) dm_seen++;
    checks++;
    if (if_ack !== 1'b0 || if_rdata !== 32'h0000_0013) begin
      errors++;
      $display("FAIL if_pulse got ack=%b rdata=%h want 0 00000013", if_ack, if_rdata);
    end
    checks++;
    if (dm_seen !== 0) begin
      errors++;
      $display("FAIL if_no_stray got %0d spurious acks want 0", dm_seen);
    end
  endtask

  task automatic test_dm_store();
    do_reset();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h8000_1000;
    dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
    step();
    checks++;
    if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h8000_1000 ||
        mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'hF) begin
      errors++;
      $display("FAIL dm_issue got req=%b we=%b addr=%h wdata=%h wstrb=%h want 1 1 80001000 deadbeef f",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    // Inputs changed mid-transaction must not leak onto the port.
    dm_wdata = 32'h1234_5678; dm_addr = 32'h0;
    step();
    checks++;
    if (dm_ack !== 1'b0 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h8000_1000) begin
      errors++;
      $display("FAIL dm_stable got ack=%b wdata=%h addr=%h want 0 deadbeef 80001000",
               dm_ack, mem_wdata, mem_addr);
    end
    mem_ack = 1'b1;
    step();
    checks++;
    if ({dm_ack, dm_err, if_ack, mem_req} !== 4'b1000) begin
      errors++;
      $display("FAIL dm_done got ack=%b err=%b ifack=%b req=%b want 1 0 0 0",
               dm_ack, dm_err, if_ack, mem_req);
    end
    mem_ack = 1'b0; dm_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] order = '0;
    logic [3:0] gaps  = '0;
    logic [3:0] acks  = '0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_1000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2000;
    for (int i = 0; i < 4; i++) begin
      step();
      order[i] = (mem_req && mem_addr == 32'h0000_2000);
      mem_ack = 1'b1; mem_rdata = 32'h100 + i;
      step();
      acks[i] = order[i] ? (dm_ack && !if_ack && dm_rdata == 32'h100 + i)
                         : (if_ack && !dm_ack && if_rdata == 32'h100 + i);
      mem_ack = 1'b0;
      step();
      gaps[i] = !mem_req && !if_ack && !dm_ack;
    end
    idle_inputs();
    checks++;
    if (order !== 4'b1010) begin
      errors++;
      $display("FAIL rr_order got dm-grant bits=%b want 1010", order);
    end
    checks++;
    if (acks !== 4'b1111) begin
      errors++;
      $display("FAIL rr_acks got %b want 1111", acks);
    end
    checks++;
    if (gaps !== 4'b1111) begin
      errors++;
      $display("FAIL rr_resp_gap got %b want 1111", gaps);
    end
  endtask

  task automatic test_timeout();
    int high = 0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0000_A5A5;
    step();
    mem_ack = 1'b0;
    step();
    step();
    if (mem_req) high++;
    for (int i = 0; i < 7; i++) begin
      step();
      if (mem_req && !if_ack) high++;
    end
    step();
    checks++;
    if (high !== 8 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL to_req_len got high=%0d req=%b want 8 0", high, mem_req);
    end
    checks++;
    if ({if_ack, if_err} !== 2'b11 || if_rdata !== 32'h0000_A5A5) begin
      errors++;
      $display("FAIL to_err got ack=%b err=%b rdata=%h want 1 1 0000a5a5",
               if_ack, if_err, if_rdata);
    end
    if_req = 1'b0;
    step();
    dm_req = 1'b1; dm_addr = 32'h0000_0080;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0000_7777;
    step();
    checks++;
    if ({dm_ack, dm_err} !== 2'b10 || dm_rdata !== 32'h0000_7777 || if_err !== 1'b0) begin
      errors++;
      $display("FAIL to_recover got ack=%b err=%b rdata=%h iferr=%b want 1 0 00007777 0",
               dm_ack, dm_err, dm_rdata, if_err);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_busy();
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0400;
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({mem_req, if_ack, if_err, dm_ack, dm_err} !== 5'b0) begin
      errors++;
      $display("FAIL rst_busy got req/ifack/iferr/dmack/dmerr=%b want 00000",
               {mem_req, if_ack, if_err, dm_ack, dm_err});
    end
    rst = 1'b0; if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, if_ack, dm_ack} !== 3'b0 || if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_stray got req=%b ifack=%b dmack=%b ifr=%h want 0 0 0 0",
               mem_req, if_ack, dm_ack, if_rdata);
    end
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0100;
    step();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (dm_ack4 !== 1'b0 || mem_req4 !== 1'b1) begin
      errors++;
      $display("FAIL t4_pending got ack=%b req=%b want 0 1", dm_ack4, mem_req4);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_5555;
    step();
    checks++;
    if ({dm_ack4, dm_err4, mem_req4} !== 3'b100 || dm_rdata4 !== 32'h0000_5555) begin
      errors++;
      $display("FAIL t4_ack_wins got ack=%b err=%b req=%b rdata=%h want 1 0 0 00005555",
               dm_ack4, dm_err4, mem_req4, dm_rdata4);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_if_read();
    test_dm_store();
    test_back_to_back();
    test_timeout();
    test_reset_busy();
    test_ack_at_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
